// File: rtl/cont_gray_param.sv
// Parametrised Gray-code counter over MOD states, centred in the code space.
// Optional up/down direction enabled by defining CONT_GRAY_UPDOWN_EN.
module cont_gray_param #(
  parameter int WIDTH = 3,
  parameter int MOD   = 6
) (
  input  logic             ck,
  input  logic             clr,
  input  logic             en,
  input  logic             dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] idx,
  output logic             tc,
  output logic             err
);

  localparam int OFFSET = ((2 ** WIDTH) - MOD) / 2;

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("cont_gray_param: WIDTH out of range");
    end
    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
      $error("cont_gray_param: MOD out of range");
    end
  endgenerate

  localparam logic [WIDTH:0]   OFF_W = (WIDTH+1)'(OFFSET);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] A_RST = OFF_W[WIDTH-1:0] ^ OFF_W[WIDTH:1];

  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic             r_err;

  logic             w_dn;
  logic             w_ld_ok;
  logic             w_at_last;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_nxt_idx;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nxt_a;

`ifdef CONT_GRAY_UPDOWN_EN
  assign w_dn = dn;
`else
  logic w_unused_dn;
  assign w_unused_dn = dn;
  assign w_dn        = 1'b0;
`endif

  assign w_ld_ok   = ({1'b0, d} < MOD_W);
  assign w_at_last = (r_idx == LAST);
  assign w_at_zero = (r_idx == '0);

  always_comb begin
    w_step = r_idx;
    if (w_dn)
      w_step = w_at_zero ? LAST : r_idx - ONE;
    else
      w_step = w_at_last ? '0 : r_idx + ONE;
  end

  always_comb begin
    w_nxt_idx = r_idx;
    if (ld) begin
      if (w_ld_ok)
        w_nxt_idx = d;
    end else if (en) begin
      w_nxt_idx = w_step;
    end
  end

  // Gray code of the offset index; sum never overflows WIDTH+1 bits
  assign w_sum   = {1'b0, w_nxt_idx} + OFF_W;
  assign w_nxt_a = w_sum[WIDTH-1:0] ^ w_sum[WIDTH:1];

  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      r_idx <= '0;
      r_a   <= A_RST;
      r_err <= 1'b0;
    end else begin
      r_idx <= w_nxt_idx;
      r_a   <= w_nxt_a;
      r_err <= ld & ~w_ld_ok;
    end
  end

  assign a   = r_a;
  assign idx = r_idx;
  assign err = r_err;
  assign tc  = en & ~ld & (w_dn ? w_at_zero : w_at_last);

endmodule

// File: tb/tb_cont_gray_param.sv
// Bench for cont_gray_param: three instances (3/6, 3/7, 4/10)
// against an arithmetic reference model.
module tb_cont_gray_param;

  logic       ck = 1'b0;
  logic       clr, en, dn, ld;
  logic [2:0] d0, d1;
  logic [3:0] d2;
  logic [2:0] a0, i0, a1, i1;
  logic [3:0] a2, i2;
  logic       tc0, tc1, tc2, er0, er1, er2;

  int checks = 0;
  int errors = 0;

  int W[3] = '{3, 3, 4};
  int M[3] = '{6, 7, 10};
  int m_idx[3];
  bit m_err[3];

  always #5 ck = ~ck;

  cont_gray_param #(.WIDTH(3), .MOD(6)) u0 (
    .ck(ck), .clr(clr), .en(en), .dn(dn), .ld(ld), .d(d0),
    .a(a0), .idx(i0), .tc(tc0), .err(er0));

  cont_gray_param #(.WIDTH(3), .MOD(7)) u1 (
    .ck(ck), .clr(clr), .en(en), .dn(dn), .ld(ld), .d(d1),
    .a(a1), .idx(i1), .tc(tc1), .err(er1));

  cont_gray_param #(.WIDTH(4), .MOD(10)) u2 (
    .ck(ck), .clr(clr), .en(en), .dn(dn), .ld(ld), .d(d2),
    .a(a2), .idx(i2), .tc(tc2), .err(er2));

  function automatic bit down_eff(bit dd);
`ifdef CONT_GRAY_UPDOWN_EN
    return dd;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int gray_of(int k, int i);
    int b;
    b = i + ((1 << W[k]) - M[k]) / 2;
    return b ^ (b / 2);
  endfunction

  function automatic logic [31:0] obs_a(int k);
    case (k)
      0: return 32'(a0);
      1: return 32'(a1);
      default: return 32'(a2);
    endcase
  endfunction

  function automatic logic [31:0] obs_i(int k);
    case (k)
      0: return 32'(i0);
      1: return 32'(i1);
      default: return 32'(i2);
    endcase
  endfunction

  function automatic logic [31:0] obs_tc(int k);
    case (k)
      0: return 32'(tc0);
      1: return 32'(tc1);
      default: return 32'(tc2);
    endcase
  endfunction

  function automatic logic [31:0] obs_err(int k);
    case (k)
      0: return 32'(er0);
      1: return 32'(er1);
      default: return 32'(er2);
    endcase
  endfunction

  task automatic chk(string tag, int k, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, o, e);
    end
  endtask

  task automatic check_state(string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_a"}, k, obs_a(k), 32'(gray_of(k, m_idx[k])));
      chk({tag, "_idx"}, k, obs_i(k), 32'(m_idx[k]));
      chk({tag, "_err"}, k, obs_err(k), 32'(m_err[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0;
      m_err[k] = 1'b0;
    end
  endtask

  task automatic step(bit e, bit dd, bit l, int v0, int v1, int v2);
    int          dv[3];
    int          pre[3];
    logic [31:0] pa[3];
    bit          down;
    bit          wrap;
    dv[0] = v0; dv[1] = v1; dv[2] = v2;
    en = e; dn = dd; ld = l;
    d0 = 3'(v0); d1 = 3'(v1); d2 = 4'(v2);
    down = down_eff(dd);
    #4;
    for (int k = 0; k < 3; k++) begin
      pre[k] = m_idx[k];
      pa[k]  = obs_a(k);
      chk("tc", k, obs_tc(k),
          32'(e && !l && (down ? m_idx[k] == 0 : m_idx[k] == M[k] - 1)));
      if (l) begin
        m_err[k] = (dv[k] >= M[k]);
        if (dv[k] < M[k]) m_idx[k] = dv[k];
      end else begin
        m_err[k] = 1'b0;
        if (e)
          m_idx[k] = down ? (m_idx[k] + M[k] - 1) % M[k]
                          : (m_idx[k] + 1) % M[k];
      end
    end
    @(posedge ck);
    #1;
    check_state("step");
    if (!l && e) begin
      for (int k = 0; k < 3; k++) begin
        wrap = down ? (pre[k] == 0) : (pre[k] == M[k] - 1);
        if (M[k] % 2 == 0 || !wrap)
          chk("unit", k, 32'($countones(obs_a(k) ^ pa[k])), 32'd1);
      end
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    en = 1'b0; dn = 1'b0; ld = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    model_reset();
    repeat (2) @(posedge ck);
    #1;
    check_state("rst");
    clr = 1'b0;
  endtask

  int up_a[7] = '{1, 3, 2, 6, 7, 5, 1};
  int odd_a[8] = '{0, 1, 3, 2, 6, 7, 5, 0};

  initial begin
    do_reset();
    chk("rst_lit_a", 0, 32'(a0), 32'h1);
    chk("rst_lit_a", 1, 32'(a1), 32'h0);
    chk("rst_lit_a", 2, 32'(a2), 32'h2);

    for (int s = 0; s < 7; s++) begin
      chk("up_lit", 0, 32'(a0), 32'(up_a[s]));
      chk("odd_lit", 1, 32'(a1), 32'(odd_a[s]));
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    end
    chk("odd_lit", 1, 32'(a1), 32'(odd_a[7]));

    do_reset();
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
`ifdef CONT_GRAY_UPDOWN_EN
    chk("dn_lit", 0, 32'(a0), 32'h5);
`else
    chk("dn_lit", 0, 32'(a0), 32'h3);
`endif
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);

    step(1'b0, 1'b0, 1'b1, 4, 4, 4);
    chk("ld_lit", 0, 32'(a0), 32'h7);
    step(1'b1, 1'b0, 1'b1, 6, 6, 15);
    chk("bad_lit", 0, 32'(er0), 32'h1);
    step(1'b0, 1'b1, 1'b1, 7, 7, 12);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("err_drop", 0, 32'(er0), 32'h0);

    step(1'b0, 1'b0, 1'b1, 3, 3, 3);
    en = 1'b1; ld = 1'b1;
    d0 = 3'd5; d1 = 3'd5; d2 = 4'd5;
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_state("aclr");
    @(posedge ck);
    #1;
    check_state("aclr_hold");
    clr = 1'b0; ld = 1'b0;

    do_reset();
    for (int s = 0; s < 5; s++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("hold_lit", 2, 32'(a2), 32'h2);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("hold_go", 2, 32'(a2), 32'h6);
    for (int s = 0; s < 9; s++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("wrap10", 2, 32'(a2), 32'h2);

    for (int s = 0; s < 300; s++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
